config_bitstream_tx: RTL and testbench
======================================

CONFIG_BITSTREAM_TX -- requirements
Module: config_bitstream_tx

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 16'hFAB2, marking the end of each 32-bit data frame.
REQ-002 SHALL have parameter END_WORD, default 16'hFAB3, the terminator sent after the last frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the input buffer depth in words (power of two, at least 2).
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 resetn  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_ready  output  1  buffer can accept a word; equals not-full.
REQ-008 s_data  input  32  configuration word.
REQ-009 s_last  input  1  word is the final word of the transfer.
REQ-010 tx_bit  output  1  registered serial bitstream, MSB-first, one bit per clk.
REQ-011 busy  output  1  FSM not in IDLE.
REQ-012 done  output  1  one-cycle pulse after the terminator completes.
REQ-013 underrun  output  1  sticky; buffer was empty at a frame boundary before s_last was sent.
REQ-014 word_count  output  16  frames fully sent in the current or most recent transfer.

Function
REQ-015 SHALL accept a word (s_data plus s_last) into the FIFO on each edge where s_valid and s_ready are both high; words are not dropped or reordered.
REQ-016 SHALL implement FSM states IDLE, DATA, SYNC, TRAIL and DONE, with a bit counter for the current field.
REQ-017 In IDLE, tx_bit SHALL be 0; on the first edge where the FIFO is non-empty, the FSM SHALL pop a word, enter DATA and drive tx_bit with word bit 31 from that same edge.
REQ-018 A word accepted at edge N into an empty, idle block SHALL put bit 31 on tx_bit after edge N+1.
REQ-019 DATA SHALL send bits 31..0 over 32 consecutive cycles, then SYNC SHALL send SYNC_WORD bits 15..0 over 16 cycles; each frame is 48 contiguous bits.
REQ-020 At the last SYNC bit, word_count SHALL increment, saturating at 16'hFFFF.
REQ-021 On leaving SYNC, the FSM SHALL go to TRAIL if the frame had s_last set.
REQ-022 Otherwise, on leaving SYNC with the FIFO non-empty, it SHALL pop the next word and enter DATA with no gap cycle.
REQ-023 Otherwise, on leaving SYNC with the FIFO empty, it SHALL set underrun and enter TRAIL.
REQ-024 TRAIL SHALL send END_WORD bits 15..0 over 16 cycles, then enter DONE.
REQ-025 DONE SHALL last one cycle with done=1 and tx_bit=0, then enter IDLE.
REQ-026 Frames SHALL never have gaps between them, so a downstream receiver with a 49-cycle inactivity timeout never expires mid-transfer.
REQ-027 Words written while the FSM is in TRAIL or DONE SHALL stay in the FIFO and start the next transfer from IDLE.
REQ-028 A simultaneous push and pop on a full FIFO SHALL NOT be accepted, because s_ready is low when full.
REQ-029 A simultaneous push and pop on a non-full FIFO SHALL keep the occupancy count unchanged.
REQ-030 On the IDLE-to-DATA transition, word_count and underrun SHALL clear; both SHALL hold their values through DONE and IDLE.
REQ-031 busy SHALL be 1 in DATA, SYNC, TRAIL and DONE.

Reset
REQ-032 resetn low SHALL immediately force state IDLE, tx_bit=0, done=0, underrun=0, word_count=0, an empty FIFO and s_ready=1.
REQ-033 Assertion of resetn mid-frame SHALL abandon the frame without sending END_WORD.
REQ-034 After resetn deasserts, the block SHALL wait in IDLE for new input.

Verification
REQ-035 Push 0xDEADBEEF with s_last=1 at edge N -> tx_bit carries DEADBEEF, then FAB2, then FAB3, MSB-first, over edges N+1..N+64; done=1 after edge N+65; word_count=1; underrun=0.
REQ-036 Push 0x11111111, 0x22222222, then 0x33333333 with s_last=1, fed into a receiver model that raises a strobe whenever the low 16 bits of its 48-bit shift register equal FAB2 -> strobes yield the three words in order, exactly 48 cycles apart; word_count=3.
REQ-037 Push 0xA5A5A5A5 with s_last=0 and nothing else -> FAB3 follows the first SYNC; underrun=1; word_count=1; done pulses once.
REQ-038 Hold s_valid high with the FSM busy -> s_ready drops after 4 buffered words; no word lost or duplicated; stream order preserved.
REQ-039 Assert resetn low at bit 10 of the second DATA field -> tx_bit=0 immediately; all outputs at reset values; a new single-word transfer after release matches REQ-035.

Source files
------------

// File: rtl/config_bitstream_tx.sv
// Serialises buffered 32-bit config words as DATA+SYNC frames, then END_WORD and a done pulse.
// A small FIFO decouples the upstream; frames are sent back-to-back while words are available.
module config_bitstream_tx #(
  parameter logic [15:0] SYNC_WORD  = 16'hFAB2,
  parameter logic [15:0] END_WORD   = 16'hFAB3,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        tx_bit,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic [15:0] word_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DATA  = 3'd1;
  localparam logic [2:0] SYNC  = 3'd2;
  localparam logic [2:0] TRAIL = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [32:0]   head;
  logic          empty;
  logic          push;
  logic          pop;

  logic [2:0]  state;
  logic [4:0]  cnt;
  logic [31:0] shreg;
  logic        cur_last;
  logic        frame_end;

  assign empty     = (count == '0);
  assign s_ready   = (count != FULL_CNT);
  assign head      = mem[rd_ptr];
  assign push      = s_valid && s_ready;
  assign frame_end = (state == SYNC) && (cnt == 5'd0);
  // Pop at the same edge that shows bit 31, both from IDLE and back-to-back after SYNC.
  assign pop       = !empty && ((state == IDLE) || (frame_end && !cur_last));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_last, s_data};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      cur_last   <= 1'b0;
      tx_bit     <= 1'b0;
      word_count <= '0;
      underrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_bit <= 1'b0;
          if (!empty) begin
            state      <= DATA;
            tx_bit     <= head[31];
            shreg      <= {head[30:0], 1'b0};
            cnt        <= 5'd31;
            cur_last   <= head[32];
            word_count <= '0;
            underrun   <= 1'b0;
          end
        end
        DATA: begin
          if (cnt == 5'd0) begin
            state  <= SYNC;
            tx_bit <= SYNC_WORD[15];
            shreg  <= {SYNC_WORD[14:0], 17'd0};
            cnt    <= 5'd15;
          end else begin
            tx_bit <= shreg[31];
            shreg  <= {shreg[30:0], 1'b0};
            cnt    <= cnt - 1'b1;
          end
        end
        SYNC: begin
          if (cnt == 5'd0) begin
            if (word_count != 16'hFFFF) word_count <= word_count + 1'b1;
            if (!cur_last && !empty) begin
              state    <= DATA;
              tx_bit   <= head[31];
              shreg    <= {head[30:0], 1'b0};
              cnt      <= 5'd31;
              cur_last <= head[32];
            end else begin
              if (!cur_last) underrun <= 1'b1;
              state  <= TRAIL;
              tx_bit <= END_WORD[15];
              shreg  <= {END_WORD[14:0], 17'd0};
              cnt    <= 5'd15;
            end
          end else begin
            tx_bit <= shreg[31];
            shreg  <= {shreg[30:0], 1'b0};
            cnt    <= cnt - 1'b1;
          end
        end
        TRAIL: begin
          if (cnt == 5'd0) begin
            state  <= DONE;
            tx_bit <= 1'b0;
          end else begin
            tx_bit <= shreg[31];
            shreg  <= {shreg[30:0], 1'b0};
            cnt    <= cnt - 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          tx_bit <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          tx_bit <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_bitstream_tx.sv
// Directed bench for config_bitstream_tx: single frame, multi-frame, underrun, backpressure, mid-frame reset.
module tb_config_bitstream_tx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        tx_bit;
  logic        busy;
  logic        done;
  logic        underrun;
  logic [15:0] word_count;

  int n_checks = 0;
  int n_fail   = 0;

  config_bitstream_tx dut (
    .clk        (clk),
    .resetn     (resetn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .tx_bit     (tx_bit),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Receiver model: 48-bit shift register, strobes when the low 16 bits match the sync word.
  logic [47:0] rx_sr = '0;
  logic [31:0] rx_words[$];
  int          rx_cyc[$];
  int          cyc = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    rx_sr = {rx_sr[46:0], tx_bit};
    if (rx_sr[15:0] == 16'hFAB2) begin
      rx_words.push_back(rx_sr[47:16]);
      rx_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) break;
    end
    check(tag, done, 1'b1);
  endtask

  // One-word transfer pushed into an idle, empty block; checks exact bit timing.
  task automatic single_frame(input string tag, input logic [31:0] w, input logic last,
                              input logic exp_und);
    logic [63:0] got;
    int d0;
    d0 = done_cnt;
    s_valid = 1'b1; s_data = w; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    check({tag, "_lat0"}, {busy, tx_bit}, 2'b00);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      got[63-i] = tx_bit;
    end
    check({tag, "_stream"}, got, {w, 16'hFAB2, 16'hFAB3});
    check({tag, "_pre_done"}, done, 1'b0);
    @(posedge clk); #1;
    check({tag, "_done"}, {done, tx_bit, busy}, 3'b101);
    check({tag, "_wc"}, word_count, 16'd1);
    check({tag, "_und"}, underrun, exp_und);
    @(posedge clk); #1;
    check({tag, "_idle"}, {done, busy, tx_bit}, 3'b000);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_hold"}, {word_count, underrun}, {16'd1, exp_und});
  endtask

  logic [31:0] words[8];
  int          idx;
  int          acc_at_full;
  logic        rdy;
  int          guard;

  initial begin
    resetn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    #12;
    check("rst_outputs", {tx_bit, done, underrun, busy, s_ready}, 5'b00001);
    check("rst_wc", word_count, 16'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    single_frame("single", 32'hDEADBEEF, 1'b1, 1'b0);

    // Three chained frames observed through the receiver model.
    rx_words.delete(); rx_cyc.delete();
    s_valid = 1'b1;
    s_data = 32'h11111111; s_last = 1'b0; @(posedge clk); #1;
    s_data = 32'h22222222;                 @(posedge clk); #1;
    s_data = 32'h33333333; s_last = 1'b1;  @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    wait_done("multi_timeout", 400);
    check("multi_wc", word_count, 16'd3);
    check("multi_und", underrun, 1'b0);
    check("multi_nstrobe", rx_words.size(), 3);
    if (rx_words.size() == 3) begin
      check("multi_w0", rx_words[0], 32'h11111111);
      check("multi_w1", rx_words[1], 32'h22222222);
      check("multi_w2", rx_words[2], 32'h33333333);
      check("multi_gap01", rx_cyc[1] - rx_cyc[0], 48);
      check("multi_gap12", rx_cyc[2] - rx_cyc[1], 48);
    end
    repeat (3) @(posedge clk);
    #1;

    single_frame("underrun", 32'hA5A5A5A5, 1'b0, 1'b1);

    // Backpressure: hold s_valid with eight words.
    for (int i = 0; i < 8; i++) words[i] = 32'h11111111 * (i + 1);
    rx_words.delete(); rx_cyc.delete();
    idx = 0; acc_at_full = -1; guard = 0;
    s_valid = 1'b1;
    while (idx < 8 && guard < 600) begin
      s_data = words[idx]; s_last = (idx == 7);
      rdy = s_ready;
      @(posedge clk); #1;
      if (rdy) idx++;
      if (!s_ready && acc_at_full < 0) acc_at_full = idx;
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("bp_all_pushed", idx, 8);
    check("bp_full_after", acc_at_full, 5);
    wait_done("bp_timeout", 600);
    check("bp_wc", word_count, 16'd8);
    check("bp_und", underrun, 1'b0);
    check("bp_nstrobe", rx_words.size(), 8);
    if (rx_words.size() == 8) begin
      for (int i = 0; i < 8; i++) check($sformatf("bp_w%0d", i), rx_words[i], words[i]);
      for (int i = 1; i < 8; i++) check($sformatf("bp_gap%0d", i), rx_cyc[i] - rx_cyc[i-1], 48);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset at bit 10 of the second DATA field, with a third word still buffered.
    s_valid = 1'b1;
    s_data = 32'hCAFEF00D; s_last = 1'b0; @(posedge clk); #1;
    s_data = 32'h12345678; s_last = 1'b1; @(posedge clk); #1;
    s_data = 32'h0F0F0F0F; s_last = 1'b1; @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (68) @(posedge clk);
    #1;
    check("mid_bit10", tx_bit, 1'b1);
    check("mid_wc", word_count, 16'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_outputs", {tx_bit, done, underrun, busy, s_ready}, 5'b00001);
    check("mid_rst_wc", word_count, 16'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_idle", {busy, tx_bit, s_ready}, 3'b001);

    single_frame("after_rst", 32'hDEADBEEF, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
